// File: rtl/q2_memio.sv
// q2_memio: on-chip RAM in the lower address half and NCHAN buffered output FIFOs in
// the upper half, served through the q2 rdm/wrm/rdy strobe handshake with wait states.
module q2_memio #(
    parameter int WIDTH = 12,
    parameter int AW    = 12,
    parameter int NCHAN = 2,
    parameter int DEPTH = 4,
    parameter int WAIT  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          abus,
    input  logic [WIDTH-1:0]       dbus_in,
    output logic [WIDTH-1:0]       dbus_out,
    input  logic                   rdm,
    input  logic                   wrm,
    output logic                   rdy,
    output logic                   err,
    output logic [NCHAN*WIDTH-1:0] out_data,
    output logic [NCHAN-1:0]       out_valid,
    input  logic [NCHAN-1:0]       out_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = AW - 1;
    localparam logic [3:0] NCH = 4'(NCHAN);

    typedef enum logic [2:0] {IDLE, WAITC, STALL, ACK, HOLD} state_t;

    state_t           state_q;
    logic [AW-1:0]    addr_q;
    logic             wr_q;
    logic             rdy_q;
    logic             err_q;
    logic [2:0]       wcnt_q;
    logic [WIDTH-1:0] dout_q;

    logic [WIDTH-1:0] ram_q  [2**RW];
    logic [WIDTH-1:0] fifo_q [NCHAN][DEPTH];
    logic [PW-1:0]    wp_q   [NCHAN];
    logic [PW-1:0]    rp_q   [NCHAN];
    logic [CW-1:0]    cnt_q  [NCHAN];

    logic             strobe;
    logic             cur_wr;
    logic             cur_io;
    logic             cur_ok;
    logic             blocked;
    logic             go_ack;
    logic [AW-1:0]    cur_addr;
    logic [2:0]       cur_ch;
    logic [NCHAN-1:0] pop;
    logic [NCHAN-1:0] push;
    logic [NCHAN-1:0] full;
    logic [WIDTH-1:0] rd_data;

    // In IDLE the access is decoded straight from the bus so WAIT=0 completes in one cycle.
    always_comb begin
        strobe   = rdm | wrm;
        cur_addr = (state_q == IDLE) ? abus : addr_q;
        cur_wr   = (state_q == IDLE) ? wrm : wr_q;
        cur_io   = cur_addr[AW-1];
        cur_ch   = cur_addr[2:0];
        cur_ok   = cur_io && ({1'b0, cur_ch} < NCH);
        blocked  = 1'b0;
        rd_data  = '0;
        full     = '0;
        pop      = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            full[c] = (cnt_q[c] == CW'(DEPTH));
            pop[c]  = out_valid[c] & out_ready[c];
            if (cur_ok && (cur_ch == 3'(c))) begin
                blocked       = cur_wr && full[c] && !pop[c];
                rd_data[CW:1] = cnt_q[c];
                rd_data[0]    = full[c];
            end
        end
        if (!cur_io) begin
            rd_data = ram_q[cur_addr[RW-1:0]];
        end
        case (state_q)
            IDLE:    go_ack = strobe && (WAIT == 0) && !blocked;
            WAITC:   go_ack = strobe && (wcnt_q == '0) && !blocked;
            STALL:   go_ack = strobe && !blocked;
            default: go_ack = 1'b0;
        endcase
        push = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            push[c] = go_ack && cur_wr && cur_ok && (cur_ch == 3'(c));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wcnt_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            rdy_q <= go_ack;
            if (go_ack && !cur_wr) begin
                dout_q <= rd_data;
            end
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        addr_q <= abus;
                        wr_q   <= wrm;
                        if (rdm && wrm) begin
                            err_q <= 1'b1;
                        end
                        if (WAIT != 0) begin
                            state_q <= WAITC;
                            wcnt_q  <= 3'(WAIT - 1);
                        end else begin
                            state_q <= go_ack ? ACK : STALL;
                        end
                    end
                end
                WAITC: begin
                    if (!strobe) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end else begin
                        state_q <= go_ack ? ACK : STALL;
                    end
                end
                STALL: begin
                    if (!strobe) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (go_ack) begin
                        state_q <= ACK;
                    end
                end
                ACK:     state_q <= HOLD;
                HOLD:    if (!strobe) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (go_ack && cur_wr && !cur_io) begin
            ram_q[cur_addr[RW-1:0]] <= dbus_in;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (push[c]) begin
                fifo_q[c][wp_q[c]] <= dbus_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                if (push[c]) wp_q[c] <= wp_q[c] + PW'(1);
                if (pop[c])  rp_q[c] <= rp_q[c] + PW'(1);
                if (push[c] && !pop[c]) begin
                    cnt_q[c] <= cnt_q[c] + CW'(1);
                end else if (!push[c] && pop[c]) begin
                    cnt_q[c] <= cnt_q[c] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            out_valid[c]                 = (cnt_q[c] != '0);
            out_data[c*WIDTH +: WIDTH]   = fifo_q[c][rp_q[c]];
        end
    end

    assign dbus_out = dout_q;
    assign rdy      = rdy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_q2_memio.sv
// Directed + randomized bench for q2_memio: a WAIT=0 instance carries most steps,
// a WAIT=3 instance checks wait-state latency; expectations come from queue/array models.
module tb_q2_memio;
    localparam int W  = 12;
    localparam int AW = 12;
    localparam int NC = 2;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   abus = '0;
    logic [W-1:0]    dbus_in = '0;
    logic [W-1:0]    dbus_out;
    logic            rdm = 1'b0;
    logic            wrm = 1'b0;
    logic            rdy;
    logic            err;
    logic [NC*W-1:0] out_data;
    logic [NC-1:0]   out_valid;
    logic [NC-1:0]   out_ready = '0;

    logic [AW-1:0]   abus3 = '0;
    logic [W-1:0]    dbus_in3 = '0;
    logic [W-1:0]    dbus_out3;
    logic            rdm3 = 1'b0;
    logic            wrm3 = 1'b0;
    logic            rdy3;
    logic            err3;
    logic [NC*W-1:0] out_data3;
    logic [NC-1:0]   out_valid3;
    logic [NC-1:0]   out_ready3 = '1;

    q2_memio #(.WIDTH(W), .AW(AW), .NCHAN(NC), .DEPTH(DP), .WAIT(0)) u_dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .dbus_out(dbus_out),
        .rdm(rdm), .wrm(wrm), .rdy(rdy), .err(err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    q2_memio #(.WIDTH(W), .AW(AW), .NCHAN(NC), .DEPTH(DP), .WAIT(3)) u_dut3 (
        .clk(clk), .rst(rst), .abus(abus3), .dbus_in(dbus_in3), .dbus_out(dbus_out3),
        .rdm(rdm3), .wrm(wrm3), .rdy(rdy3), .err(err3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0] mram [2][2048];
    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];
    logic [W-1:0] last_pop1 = '0;
    int           pops1 = 0;
    logic         merr = 1'b0;
    logic [W-1:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mstatus(input int c);
        int n;
        n = (c == 0) ? mq0.size() : mq1.size();
        return W'(n * 2 + ((n == DP) ? 1 : 0));
    endfunction

    function automatic logic [NC-1:0] mvalid();
        return {mq1.size() != 0, mq0.size() != 0};
    endfunction

    // Sink side: a word leaves at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid[0] && out_ready[0]) begin
                if (mq0.size() == 0) chk("pop0_unexp", 32'(out_valid[0]), 0);
                else begin
                    mon_e = mq0.pop_front();
                    chk("pop0_data", 32'(out_data[W-1:0]), 32'(mon_e));
                end
            end
            if (out_valid[1] && out_ready[1]) begin
                if (mq1.size() == 0) chk("pop1_unexp", 32'(out_valid[1]), 0);
                else begin
                    mon_e = mq1.pop_front();
                    chk("pop1_data", 32'(out_data[2*W-1:W]), 32'(mon_e));
                    last_pop1 = mon_e;
                    pops1++;
                end
            end
        end
    end

    task automatic access(input bit sel, input bit w, input bit r, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input int exp_lat, input string tag);
        int n;
        logic got;
        logic [W-1:0] exp;
        n = 0;
        if (sel) begin wrm3 = w; rdm3 = r; abus3 = a; dbus_in3 = d; end
        else     begin wrm  = w; rdm  = r; abus  = a; dbus_in  = d; end
        do begin
            @(posedge clk); #1;
            n++;
            got = sel ? rdy3 : rdy;
        end while (!got && n < 20);
        chk({tag, "_rdy"}, 32'(got), 1);
        if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
        if (got) begin
            if (w) begin
                if (!a[AW-1]) mram[sel][a[10:0]] = d;
                else if (!sel && a[2:0] == 3'd0) mq0.push_back(d);
                else if (!sel && a[2:0] == 3'd1) mq1.push_back(d);
                if (r && !sel) merr = 1'b1;
            end else begin
                if (!a[AW-1]) exp = mram[sel][a[10:0]];
                else if (a[2:0] < 3'(NC)) exp = mstatus(int'(a[2:0]));
                else exp = '0;
                chk({tag, "_data"}, 32'(sel ? dbus_out3 : dbus_out), 32'(exp));
            end
        end
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(sel ? rdy3 : rdy), 0);
        @(posedge clk); #1;
        chk({tag, "_hold"}, 32'(sel ? rdy3 : rdy), 0);
        if (sel) begin wrm3 = 1'b0; rdm3 = 1'b0; end
        else     begin wrm  = 1'b0; rdm  = 1'b0; end
        @(posedge clk); #1;
        if (!sel) chk({tag, "_err"}, 32'(err), 32'(merr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] waddr [16];
        int k;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy), 0);
        chk("rst_dout", 32'(dbus_out), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_rdy3", 32'(rdy3), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        access(0, 1, 0, 12'h010, 12'h5A3, 1, "ram_wr");
        access(0, 0, 1, 12'h010, '0, 1, "ram_rd");
        chk("ram_valid", 32'(out_valid), 32'(mvalid()));

        for (int i = 0; i < 16; i++) begin
            waddr[i] = 11'($urandom_range(0, 2047));
            access(0, 1, 0, {1'b0, waddr[i]}, W'($urandom), 1, "rnd_wr");
        end
        for (int i = 0; i < 16; i++) begin
            k = int'($urandom_range(0, 15));
            access(0, 0, 1, {1'b0, waddr[k]}, '0, 1, "rnd_rd");
        end

        access(1, 1, 0, 12'h7FF, W'($urandom), 4, "w3_wr");
        access(1, 0, 1, 12'h7FF, '0, 4, "w3_rd");

        out_ready = 2'b00;
        for (int i = 1; i <= 4; i++) access(0, 1, 0, 12'h800, W'(i), 1, "ch0_fill");
        chk("ch0_valid", 32'(out_valid), 32'(mvalid()));
        chk("ch0_head", 32'(out_data[W-1:0]), 32'(mq0[0]));
        access(0, 0, 1, 12'h800, '0, 1, "ch0_stat");

        wrm = 1'b1; abus = 12'h800; dbus_in = 12'h005;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_rdy", 32'(rdy), 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("stall_release", 32'(rdy), 1);
        if (rdy) mq0.push_back(12'h005);
        chk("stall_head", 32'(out_data[W-1:0]), 32'(mq0[0]));
        @(posedge clk); #1;
        wrm = 1'b0;
        @(posedge clk); #1;
        chk("stall_err", 32'(err), 32'(merr));

        for (int i = 0; i < 4; i++) access(0, 1, 0, 12'h801, W'($urandom), 1, "ch1_fill");
        access(0, 0, 1, 12'h801, '0, 1, "ch1_stat");
        out_ready[1] = 1'b1;
        access(0, 1, 0, 12'h801, 12'h0AB, 1, "ch1_pushpop");
        k = 0;
        while (out_valid[1] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        out_ready[1] = 1'b0;
        chk("ch1_drained", 32'(out_valid[1]), 0);
        chk("ch1_last", 32'(last_pop1), 32'h0AB);
        chk("ch1_pops", pops1, 5);
        access(0, 0, 1, 12'h801, '0, 1, "ch1_stat_empty");

        access(0, 1, 1, 12'h020, 12'h123, 1, "both");
        access(0, 0, 1, 12'h020, '0, 1, "both_rd");
        access(0, 1, 0, 12'h805, 12'h777, 1, "bad_wr");
        chk("bad_valid", 32'(out_valid), 32'(mvalid()));
        access(0, 0, 1, 12'h805, '0, 1, "bad_rd");

        wrm = 1'b1; abus = 12'h800; dbus_in = 12'h0CC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_stall_rdy", 32'(rdy), 0);
        rst = 1'b0;
        #2;
        chk("midrst_rdy", 32'(rdy), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_err", 32'(err), 0);
        mq0.delete();
        mq1.delete();
        merr = 1'b0;
        wrm = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(0, 1, 0, 12'h800, 12'h03C, 1, "post_wr");
        chk("post_valid", 32'(out_valid), 32'(mvalid()));
        chk("post_head", 32'(out_data[W-1:0]), 32'(mq0[0]));
        access(0, 0, 1, 12'h020, '0, 1, "post_ram");

        for (int i = 0; i < 3; i++) access(0, 1, 0, 12'h800, W'($urandom), 1, "ab_fill");
        wrm = 1'b1; abus = 12'h800; dbus_in = 12'h0EE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wrm = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        merr = 1'b1;
        chk("abort_err", 32'(err), 32'(merr));
        chk("abort_rdy", 32'(rdy), 0);
        access(0, 0, 1, 12'h800, '0, 1, "abort_stat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/q2_memio.md
Name: q2_memio

Overview:
Parametrised memory and I/O responder for the q2 CPU bus. It is the synthesizable successor to the bench-level RAM model: the lower address half is on-chip RAM, and the upper half is NCHAN buffered output channels. Accesses use a strobe/ready handshake with configurable wait states and back-pressure. It sits between the q2 core's abus/dbus/rdm/wrm and the board-level output sinks.

Parameters:
WIDTH, 12, data word width (dbus width)
AW, 12, address width; RAM depth is 2^(AW-1) words
NCHAN, 2, number of output channels (1..8)
DEPTH, 4, FIFO entries per channel (power of 2, at least 2)
WAIT, 0, extra wait cycles before ready on every access (0..7)

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset
abus  in  AW  access address; held stable while rdm or wrm is high
dbus_in  in  WIDTH  write data; held stable while wrm is high
dbus_out  out  WIDTH  read data; valid when rdy=1, held until the next read completes
rdm  in  1  read strobe; level, held until rdy is seen
wrm  in  1  write strobe; level, held until rdy is seen
rdy  out  1  access complete; one-cycle pulse
err  out  1  sticky protocol error flag
out_data  out  NCHAN*WIDTH  head-of-FIFO data; channel c occupies bits [c*WIDTH +: WIDTH]
out_valid  out  NCHAN  channel FIFO not empty
out_ready  in  NCHAN  sink accepts the head word when out_valid & out_ready at a clock edge

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, rdy=0, dbus_out=0, err=0, all FIFOs empty, out_valid=0. RAM contents are not reset.
- Address map:
  - abus[AW-1]=0: RAM word abus[AW-2:0].
  - abus[AW-1]=1: I/O. Channel index = abus[2:0].
  - Index >= NCHAN: writes are discarded, reads return 0. These accesses still complete normally.
- FSM states: IDLE, WAITC, STALL, ACK, HOLD.
  - IDLE: on rdm|wrm, latch the address and direction. Go to WAITC with count=WAIT; go directly to ACK if WAIT=0.
  - WAITC: decrement count each cycle. At 0, go to ACK, or to STALL if this is an I/O write to a full FIFO.
  - STALL: stay while the target FIFO is full. Leave for ACK in the cycle after space appears.
  - ACK: perform the operation and drive rdy=1 for exactly one cycle. Go to HOLD.
  - HOLD: wait until rdm=0 and wrm=0, then go to IDLE. No new access is accepted until the strobes drop.
- Latency: rdy rises WAIT+1 cycles after the strobe is sampled in IDLE, plus any STALL cycles.
- Read data:
  - RAM read: dbus_out = ram[addr], registered in ACK.
  - I/O read of a valid channel: status word, zero-extended. bit0 = FIFO full, bits[4:1] = FIFO occupancy count.
- Write: the RAM or FIFO is written in the ACK cycle.
- rdm and wrm both high when sampled in IDLE: treat as a write and set err=1. err is cleared only by reset.
- Strobe dropped before rdy (in WAITC or STALL): abort and return to IDLE with no side effects. err is set to 1.
- FIFO:
  - Circular buffer with wrapping read and write pointers and a count of width clog2(DEPTH)+1.
  - Full when count=DEPTH; empty when count=0.
  - Push and pop on the same channel in the same cycle: count is unchanged and both pointers advance. This is legal even when full, since the pop frees the slot. STALL is exited on a concurrent pop.
  - out_data shows the head word combinationally from the buffer. Undefined while empty.
- Reset asserted mid-access: FSM returns to IDLE immediately and rdy=0. The pending write is lost.

Test Plan:
- Defaults, WAIT=0: write 0x5A3 to 0x010, then read 0x010 -> rdy pulses 1 cycle after each strobe; dbus_out=0x5A3; out_valid=0.
- WAIT=3: read RAM 0x7FF -> rdy exactly 4 cycles after the strobe; rdy low while the strobe is held in HOLD.
- out_ready=0: write 0x001..0x004 to 0x800 -> out_valid[0]=1 and out_data ch0=0x001; status read of 0x800 returns 0x009. A 5th write stalls with rdy=0. Raise out_ready for one cycle -> rdy pulses; out_data=0x002.
- Channel 1 full, out_ready[1] held high, write 0x0AB to 0x801 -> push and pop in the same cycle; count stays 4; the last entry read out is 0x0AB.
- rdm and wrm both high at addr 0x020, data 0x123 -> err=1; ram[0x020]=0x123. Write to 0x805 (NCHAN=2) -> discarded; rdy still pulses.
- Pull rst low during a 5th write in STALL -> rdy=0, all out_valid=0, err=0; the next access completes normally.
